// File: rtl/shift_reg_sequencer.sv
// rtl/shift_reg_sequencer.sv - command-driven controller for a bidirectional shift register
//
// Accepts one command at a time (load, clear, shift or rotate, 0..max steps)
// and drives the shift register's parallel/serial controls. Between commands
// the register is held by reloading its own output.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_op              0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 CLEAR, 6-7 illegal
//   cmd_count           shift/rotate steps (ignored for LOAD/CLEAR)
//   cmd_data            LOAD value; bit 0 is the fill bit for SHL/SHR
//   sr_q                shift register output
//   sr_d/load/l_r/sin   shift register controls
//   busy, done, err     status; err only meaningful with done
//   result              register snapshot taken at done

module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] sr_q,
    output logic [WIDTH-1:0] sr_d,
    output logic             sr_load,
    output logic             sr_l_r,
    output logic             sr_sin,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_SHL   = 3'd1;
    localparam logic [2:0] OP_SHR   = 3'd2;
    localparam logic [2:0] OP_ROL   = 3'd3;
    localparam logic [2:0] OP_ROR   = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               accept;
    logic               cmd_illegal;
    logic               cmd_is_param;
    logic               op_q_illegal;

    assign cmd_illegal  = (cmd_op > OP_CLEAR);
    assign cmd_is_param = (cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR);
    assign op_q_illegal = (op_q > OP_CLEAR);
    assign accept       = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_LOAD;
            data_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                // LOAD/CLEAR always take exactly one register update
                cnt_q  <= cmd_is_param ? CNT_W'(1) : cmd_count;
            end else if (state_q == S_EXEC) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_q == S_DONE) begin
                result_q <= sr_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Zero-step shifts and illegal ops never touch the register
                    if (cmd_illegal || (!cmd_is_param && cmd_count == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register controls depend only on state registers and sr_q, so a reset
    // arriving mid-command still lets the in-flight step complete.
    always_comb begin
        sr_load = 1'b1;
        sr_d    = sr_q;
        sr_l_r  = 1'b0;
        sr_sin  = 1'b0;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_LOAD:  sr_d = data_q;
                OP_CLEAR: sr_d = '0;
                OP_SHL: begin
                    sr_load = 1'b0;
                    sr_l_r  = 1'b1;
                    sr_sin  = data_q[0];
                end
                OP_SHR: begin
                    sr_load = 1'b0;
                    sr_l_r  = 1'b0;
                    sr_sin  = data_q[0];
                end
                OP_ROL: begin
                    sr_load = 1'b0;
                    sr_l_r  = 1'b1;
                    sr_sin  = sr_q[WIDTH-1];
                end
                OP_ROR: begin
                    sr_load = 1'b0;
                    sr_l_r  = 1'b0;
                    sr_sin  = sr_q[0];
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = !reset && (state_q == S_IDLE);
    assign busy      = !reset && (state_q != S_IDLE);
    assign done      = !reset && (state_q == S_DONE);
    assign err       = done && op_q_illegal;

    // During the done cycle the snapshot is shown directly from sr_q; it is
    // latched at the end of that cycle and held until the next done.
    always_comb begin
        result = result_q;
        if (reset) begin
            result = '0;
        end else if (state_q == S_DONE) begin
            result = sr_q;
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb/tb_shift_reg_sequencer.sv - directed self-checking bench for shift_reg_sequencer

module tb_shift_reg_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_count;
    logic [3:0] cmd_data;
    logic [3:0] sr_q;
    logic [3:0] sr_d;
    logic       sr_load;
    logic       sr_l_r;
    logic       sr_sin;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] result;
    logic       sr_clr;

    int n_cmp;
    int n_fail;

    shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .sr_q      (sr_q),
        .sr_d      (sr_d),
        .sr_load   (sr_load),
        .sr_l_r    (sr_l_r),
        .sr_sin    (sr_sin),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shift register: parallel load, or shift with serial-in at
    // the LSB (left) or MSB (right). Its clear is independent of the DUT reset.
    always @(posedge clk) begin
        if (sr_clr)       sr_q <= 4'b0000;
        else if (sr_load) sr_q <= sr_d;
        else if (sr_l_r)  sr_q <= {sr_q[2:0], sr_sin};
        else              sr_q <= {sr_sin, sr_q[3:1]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready_timeout got=%b want=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 3'd7;
        cmd_count = 3'd7;
        cmd_data  = 4'b1111;
    endtask

    task automatic run_load(input logic [3:0] data);
        issue(3'd0, 3'd0, data);
        step();
        step();
        n_cmp++;
        if (sr_q !== data) begin n_fail++; $display("FAIL preload_value got=%b want=%b", sr_q, data); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sr_clr = 1'b1;
        step();
        sr_clr = 1'b0;
        step();
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b want=0", cmd_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_cmp++;
        if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_done_err got=%b%b want=00", done, err); end
        n_cmp++;
        if (result !== 4'b0000) begin n_fail++; $display("FAIL rst_result got=%b want=0000", result); end
        n_cmp++;
        if (sr_load !== 1'b1 || sr_d !== sr_q || sr_sin !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold got load=%b d=%b sin=%b want load=1 d=%b sin=0", sr_load, sr_d, sr_sin, sr_q);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_load();
        issue(3'd0, 3'd5, 4'b1011);
        n_cmp++;
        if (sr_load !== 1'b1 || sr_d !== 4'b1011) begin
            n_fail++; $display("FAIL load_ctrl got load=%b d=%b want load=1 d=1011", sr_load, sr_d);
        end
        n_cmp++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL load_exec_status got busy=%b ready=%b done=%b want 1 0 0", busy, cmd_ready, done);
        end
        step();
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL load_done got done=%b err=%b want 1 0", done, err); end
        n_cmp++;
        if (result !== 4'b1011) begin n_fail++; $display("FAIL load_result got=%b want=1011", result); end
        step();
        n_cmp++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL load_idle got done=%b ready=%b busy=%b want 0 1 0", done, cmd_ready, busy);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (sr_q !== 4'b1011 || sr_load !== 1'b1 || result !== 4'b1011) begin
                n_fail++; $display("FAIL load_hold cyc=%0d got q=%b load=%b result=%b want 1011 1 1011", i, sr_q, sr_load, result);
            end
        end
    endtask

    task automatic test_shl();
        run_load(4'b0001);
        issue(3'd1, 3'd3, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (sr_load !== 1'b0 || sr_l_r !== 1'b1 || sr_sin !== 1'b1 || done !== 1'b0) begin
                n_fail++; $display("FAIL shl_ctrl cyc=%0d got load=%b lr=%b sin=%b done=%b want 0 1 1 0", i, sr_load, sr_l_r, sr_sin, done);
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1 || sr_load !== 1'b1) begin n_fail++; $display("FAIL shl_done got done=%b load=%b want 1 1", done, sr_load); end
        n_cmp++;
        if (result !== 4'b1111 || sr_q !== 4'b1111) begin n_fail++; $display("FAIL shl_result got result=%b q=%b want 1111", result, sr_q); end
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1 || result !== 4'b1111) begin
            n_fail++; $display("FAIL shl_after got ready=%b result=%b want 1 1111", cmd_ready, result);
        end
    endtask

    task automatic test_ror();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
        run_load(4'b1000);
        issue(3'd4, 3'd5, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (sr_q !== exp_seq[i]) begin n_fail++; $display("FAIL ror_step%0d got=%b want=%b", i, sr_q, exp_seq[i]); end
        end
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || result !== 4'b0100) begin
            n_fail++; $display("FAIL ror_done got done=%b err=%b result=%b want 1 0 0100", done, err, result);
        end
        step();
    endtask

    task automatic test_zero_and_illegal();
        logic [3:0] prev;
        prev = sr_q;
        issue(3'd2, 3'd0, 4'b1111);
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || sr_load !== 1'b1) begin
            n_fail++; $display("FAIL shr0_done got done=%b err=%b load=%b want 1 0 1", done, err, sr_load);
        end
        n_cmp++;
        if (sr_q !== prev || result !== prev) begin n_fail++; $display("FAIL shr0_value got q=%b result=%b want %b", sr_q, result, prev); end
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1 || sr_q !== prev) begin n_fail++; $display("FAIL shr0_idle got ready=%b q=%b want 1 %b", cmd_ready, sr_q, prev); end
        issue(3'd6, 3'd4, 4'b0110);
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b1 || sr_load !== 1'b1) begin
            n_fail++; $display("FAIL ill_done got done=%b err=%b load=%b want 1 1 1", done, err, sr_load);
        end
        n_cmp++;
        if (result !== prev || sr_q !== prev) begin n_fail++; $display("FAIL ill_value got result=%b q=%b want %b", result, sr_q, prev); end
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL ill_idle got ready=%b err=%b done=%b want 1 0 0", cmd_ready, err, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops  [4];
        logic [2:0] cnts [4];
        logic [3:0] dats [4];
        logic [3:0] exps [4];
        int cmd_idx;
        int dn;
        int cyc;
        logic acc;
        ops  = '{3'd0, 3'd1, 3'd4, 3'd5};
        cnts = '{3'd0, 3'd1, 3'd2, 3'd3};
        dats = '{4'b0101, 4'b0000, 4'b0000, 4'b1111};
        exps = '{4'b0101, 4'b1010, 4'b1010, 4'b0000};
        cmd_idx = 0;
        dn = 0;
        cyc = 0;
        cmd_valid = 1'b1;
        cmd_op = ops[0]; cmd_count = cnts[0]; cmd_data = dats[0];
        while (cyc < 60 && dn < 4) begin
            n_cmp++;
            if (cmd_ready === 1'b1 && busy === 1'b1) begin n_fail++; $display("FAIL b2b_ready_busy cyc=%0d got ready=1 busy=1 want exclusive", cyc); end
            if (done === 1'b1) begin
                n_cmp++;
                if (result !== exps[dn] || cmd_idx != dn + 1) begin
                    n_fail++; $display("FAIL b2b_done%0d got result=%b accepted=%0d want %b accepted=%0d", dn, result, cmd_idx, exps[dn], dn + 1);
                end
                dn++;
            end
            acc = (cmd_ready === 1'b1) && cmd_valid;
            step();
            cyc++;
            if (acc) begin
                cmd_idx++;
                if (cmd_idx < 4) begin
                    cmd_op = ops[cmd_idx]; cmd_count = cnts[cmd_idx]; cmd_data = dats[cmd_idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (dn != 4 || cmd_idx != 4) begin n_fail++; $display("FAIL b2b_count got dones=%0d accepts=%0d want 4 4", dn, cmd_idx); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_done cyc=%0d got=1 want=0", i); end
        end
    endtask

    task automatic test_reset_abort();
        run_load(4'b0011);
        issue(3'd3, 3'd6, 4'b0000);
        step();
        n_cmp++;
        if (sr_q !== 4'b0110 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_step1 got q=%b busy=%b want 0110 1", sr_q, busy); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_in_reset got busy=%b done=%b ready=%b want 0 0 0", busy, done, cmd_ready);
        end
        step();
        n_cmp++;
        if (sr_q !== 4'b1100) begin n_fail++; $display("FAIL abort_value got=%b want=1100", sr_q); end
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_release got ready=%b busy=%b done=%b want 1 0 0", cmd_ready, busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (done !== 1'b0 || sr_q !== 4'b1100) begin
                n_fail++; $display("FAIL abort_quiet cyc=%0d got done=%b q=%b want 0 1100", i, done, sr_q);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        sr_clr    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_count = 3'd0;
        cmd_data  = 4'b0000;
        test_reset();
        test_load();
        test_shl();
        test_ror();
        test_zero_and_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command-driven controller for the team's WIDTH-bit bidirectional shift register (parallel load D, serial-in, load and left/right controls, no hold mode). It accepts one command at a time over a valid/ready handshake. It runs load, clear, shift or rotate operations of 0–7 steps, and holds the register between commands by reloading its own output. It sits between a bus-side command source and the shift-register datapath and reports completion with a done pulse and a snapshot of the register.

## Interface
- WIDTH, 4, shift register width.
- CNT_W, 3, step-count width (max CNT_W-bit value steps per command).
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 CLEAR, 6–7 illegal.
- cmd_count  in  CNT_W  shift/rotate steps; ignored for LOAD/CLEAR.
- cmd_data  in  WIDTH  LOAD value; bit 0 is the fill bit for SHL/SHR.
- sr_q  in  WIDTH  shift register output.
- sr_d  out  WIDTH  shift register parallel input.
- sr_load  out  1  1 = parallel load, 0 = shift.
- sr_l_r  out  1  1 = shift left (toward MSB), 0 = right.
- sr_sin  out  1  serial input to shift register.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; illegal opcode.
- result  out  WIDTH  sr_q captured at done; held until next done.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - Hold: sr_load=1, sr_d=sr_q.
  - Accept on cmd_valid & cmd_ready; register op, count, data and fill.
- Transition on accept:
  - Go to EXEC with step counter = count (LOAD/CLEAR: 1).
  - SHL/SHR/ROL/ROR with count 0, or illegal op: go directly to DONE.
- EXEC: cmd_ready=0, busy=1. Controls are a function of the registered op:
  - LOAD: sr_load=1, sr_d=data.
  - CLEAR: sr_load=1, sr_d=0.
  - SHL: sr_load=0, sr_l_r=1, sr_sin=fill.
  - SHR: sr_load=0, sr_l_r=0, sr_sin=fill.
  - ROL: sr_load=0, sr_l_r=1, sr_sin=sr_q[WIDTH-1].
  - ROR: sr_load=0, sr_l_r=0, sr_sin=sr_q[0].
  - Counter decrements every EXEC cycle; leave for DONE when counter is 1.
- DONE:
  - Hold controls as in IDLE.
  - done=1, busy=1, cmd_ready=0.
  - result<=sr_q.
  - err=1 iff op is illegal.
  - Next state IDLE.
- Illegal op: shift register untouched (hold throughout); result = unchanged sr_q.
- Outside DONE, err=0 and done=0.
- sr_sin=0 whenever sr_load=1.
- The shift register's own reset is not driven by this block.

## Timing
- sr_* outputs are combinational from state registers and sr_q only; no combinational path from cmd_* inputs to sr_*.
- Command accepted at edge E0:
  - Register changes at edges E1..En.
  - done high in the cycle after En.
  - cmd_ready high again after E(n+1).
  - Occupancy n+2 cycles; LOAD/CLEAR n=1; zero-count or illegal = 2 cycles (EXEC skipped).
- One command in flight; cmd_ready=0 from accept edge until return to IDLE. cmd_* changes while not ready are ignored.
- cmd_ready is not dependent on cmd_valid.
- While reset is high:
  - cmd_ready=0, busy=0, done=0, err=0, result=0.
  - Hold controls driven.
  - State to IDLE, counter to 0.
- Reset in EXEC aborts the command. Steps already taken remain in the register. No done is issued.
- cmd_ready=1 in the first cycle after reset deasserts.

## Test plan
- Reset, then LOAD data=4'b1011 → sr_load=1, sr_d=1011 for one cycle. done with result=1011 two cycles after accept. Register then holds 1011 for 10 idle cycles.
- LOAD 0001; SHL count=3 fill=1 → sr_load=0, sr_l_r=1 for exactly 3 cycles. result=1111, done 4 cycles after accept.
- LOAD 1000; ROR count=5 → intermediate 0100, 0010, 0001, 1000. Final result=0100, err=0.
- SHR count=0, then op=6 → each completes in 2 cycles with register unchanged. err=0 for SHR, err=1 for op 6. No sr_load=0 cycle in either.
- Hold cmd_valid high with back-to-back commands → each accepted only when cmd_ready=1. Exactly one done per command, in order.
- Assert reset on the 2nd EXEC cycle of ROL count=6 (start 0011) → register keeps 2 rotations (1100). No done; cmd_ready=1 one cycle after reset drops; busy=0.
